// File: rtl/dma_master_arbiter.sv
// Round-robin arbiter sharing one DMA master port between two requesters,
// with a bounded burst per grant and read-data/response routing to the issuer.
module dma_master_arbiter #(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] p1_addr,
  input  logic        p1_en,
  input  logic [1:0]  p1_wen,
  input  logic [15:0] p1_din,
  output logic        p1_ready,
  output logic [15:0] p1_dout,
  output logic        p1_resp,
  input  logic [15:0] p2_addr,
  input  logic        p2_en,
  input  logic [1:0]  p2_wen,
  input  logic [15:0] p2_din,
  output logic        p2_ready,
  output logic [15:0] p2_dout,
  output logic        p2_resp,
  output logic [15:0] dma_addr,
  output logic        dma_en,
  output logic [1:0]  dma_wen,
  output logic [15:0] dma_din,
  input  logic        dma_ready,
  input  logic [15:0] dma_dout,
  input  logic        dma_resp,
  output logic [1:0]  grant,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN1 = 2'd1,
    ST_OWN2 = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_P1   = 2'd1,
    RSP_P2   = 2'd2
  } rsp_sel_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX);

  state_t     state_q, state_d;
  logic       last_owner_q, last_owner_d;  // 1'b0 = p1, 1'b1 = p2
  logic [3:0] burst_cnt_q, burst_cnt_d;
  rsp_sel_t   rsp_sel_q, rsp_sel_d;

  logic       accept;
  logic [3:0] burst_cnt_inc;

  // Bus mux: the owner drives the bus combinationally so a new owner can
  // present its access in the very cycle after a switch.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    dma_addr = '0;
    dma_en   = 1'b0;
    dma_wen  = '0;
    dma_din  = '0;
    p1_ready = 1'b0;
    p2_ready = 1'b0;
    unique case (state_q)
      ST_OWN1: begin
        dma_addr = p1_addr;
        dma_en   = p1_en;
        dma_wen  = p1_wen;
        dma_din  = p1_din;
        p1_ready = dma_ready & p1_en;
      end
      ST_OWN2: begin
        dma_addr = p2_addr;
        dma_en   = p2_en;
        dma_wen  = p2_wen;
        dma_din  = p2_din;
        p2_ready = dma_ready & p2_en;
      end
      default: ;
    endcase
  end

  assign accept        = dma_en & dma_ready;
  assign burst_cnt_inc = burst_cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    rsp_sel_d    = RSP_NONE;
    unique case (state_q)
      ST_IDLE: begin
        // On a tie the requester that did not own the bus last wins.
        if (p1_en && (!p2_en || last_owner_q)) state_d = ST_OWN1;
        else if (p2_en)                        state_d = ST_OWN2;
      end
      ST_OWN1: begin
        if (!p1_en) begin
          state_d      = p2_en ? ST_OWN2 : ST_IDLE;
          burst_cnt_d  = '0;
          last_owner_d = 1'b0;
        end else if (accept) begin
          rsp_sel_d = RSP_P1;
          if (burst_cnt_inc == BURST_LAST) begin
            burst_cnt_d = '0;
            if (p2_en) begin
              state_d      = ST_OWN2;
              last_owner_d = 1'b0;
            end
          end else begin
            burst_cnt_d = burst_cnt_inc;
          end
        end
      end
      ST_OWN2: begin
        if (!p2_en) begin
          state_d      = p1_en ? ST_OWN1 : ST_IDLE;
          burst_cnt_d  = '0;
          last_owner_d = 1'b1;
        end else if (accept) begin
          rsp_sel_d = RSP_P2;
          if (burst_cnt_inc == BURST_LAST) begin
            burst_cnt_d = '0;
            if (p1_en) begin
              state_d      = ST_OWN1;
              last_owner_d = 1'b1;
            end
          end else begin
            burst_cnt_d = burst_cnt_inc;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      rsp_sel_q    <= RSP_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rsp_sel_q    <= rsp_sel_d;
    end
  end

  // rsp_sel is captured at accept, so data lands on the issuer even after a switch.
  assign p1_dout  = (rsp_sel_q == RSP_P1) ? dma_dout : '0;
  assign p1_resp  = (rsp_sel_q == RSP_P1) ? dma_resp : 1'b0;
  assign p2_dout  = (rsp_sel_q == RSP_P2) ? dma_dout : '0;
  assign p2_resp  = (rsp_sel_q == RSP_P2) ? dma_resp : 1'b0;

  assign grant    = {state_q == ST_OWN2, state_q == ST_OWN1};
  assign arb_busy = (state_q != ST_IDLE);

endmodule
